// File: rtl/shader_program_scheduler_if.sv
// Handshake and memory-port bundle between the SPI instruction stream,
// the program scheduler and the shader instruction memory.
interface shader_program_scheduler_if #(
  parameter int INSTR_W = 8
);
  logic               wr_valid_i;
  logic [INSTR_W-1:0] wr_instr_i;
  logic               wr_ready_o;
  logic               abort_i;
  logic               vblank_i;
  logic               exec_busy_i;
  logic               mem_shift_o;
  logic               mem_load_o;
  logic [INSTR_W-1:0] mem_instr_o;
  logic               pending_o;
  logic               swap_done_o;
  logic [7:0]         swap_count_o;
  logic               overflow_o;

  modport master (
    output wr_valid_i, wr_instr_i, abort_i, vblank_i, exec_busy_i,
    input  wr_ready_o, mem_shift_o, mem_load_o, mem_instr_o,
           pending_o, swap_done_o, swap_count_o, overflow_o
  );

  modport slave (
    input  wr_valid_i, wr_instr_i, abort_i, vblank_i, exec_busy_i,
    output wr_ready_o, mem_shift_o, mem_load_o, mem_instr_o,
           pending_o, swap_done_o, swap_count_o, overflow_o
  );
endinterface

// File: rtl/shader_program_scheduler.sv
// Stages a complete shader program from the SPI receiver and copies it into
// the shader instruction memory in one burst while blanking and idle.
module shader_program_scheduler #(
  parameter int NUM_INSTR = 12,
  parameter int INSTR_W   = 8
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  shader_program_scheduler_if.slave bus
);

  localparam int               PTR_W    = $clog2(NUM_INSTR);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_INSTR - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PENDING,
    COPY
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   wp;
  logic [PTR_W-1:0]   rp;
  logic [INSTR_W-1:0] stage_buf [NUM_INSTR];

  logic               wr_ready;
  logic               accept;
  logic               copy_step;
  logic               copy_drain;

  logic               mem_strobe_q;
  logic [INSTR_W-1:0] mem_instr_q;
  logic               pending_q;
  logic               swap_done_q;
  logic [7:0]         swap_count_q;
  logic               overflow_q;

  assign wr_ready = (state == IDLE) || (state == FILL);

  assign bus.wr_ready_o   = wr_ready;
  assign bus.mem_shift_o  = mem_strobe_q;
  assign bus.mem_load_o   = mem_strobe_q;
  assign bus.mem_instr_o  = mem_instr_q;
  assign bus.pending_o    = pending_q;
  assign bus.swap_done_o  = swap_done_q;
  assign bus.swap_count_o = swap_count_q;
  assign bus.overflow_o   = overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The strobe register doubles as the copy phase marker: once rp has wrapped
  // the strobe falls for one drain cycle, then the swap is reported.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    copy_step  = 1'b0;
    copy_drain = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.wr_valid_i && !bus.abort_i) begin
          accept     = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (bus.abort_i) begin
          state_next = IDLE;
        end else if (bus.wr_valid_i) begin
          accept = 1'b1;
          if (wp == LAST_IDX) begin
            state_next = PENDING;
          end
        end
      end
      PENDING: begin
        if (bus.abort_i) begin
          state_next = IDLE;
        end else if (bus.vblank_i && !bus.exec_busy_i) begin
          copy_step  = 1'b1;
          state_next = COPY;
        end
      end
      COPY: begin
        if (mem_strobe_q) begin
          copy_step = (rp != '0);
        end else begin
          copy_drain = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      stage_buf[wp] <= bus.wr_instr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp           <= '0;
      rp           <= '0;
      mem_strobe_q <= 1'b0;
      mem_instr_q  <= '0;
      pending_q    <= 1'b0;
      swap_done_q  <= 1'b0;
      swap_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (accept) begin
        wp <= (wp == LAST_IDX) ? '0 : wp + 1'b1;
      end else if (bus.abort_i && (state == FILL || state == PENDING)) begin
        wp <= '0;
      end

      if (copy_step) begin
        rp <= (rp == LAST_IDX) ? '0 : rp + 1'b1;
      end

      mem_strobe_q <= copy_step;
      mem_instr_q  <= copy_step ? stage_buf[rp] : '0;
      pending_q    <= (state_next == PENDING);
      swap_done_q  <= copy_drain;
      if (copy_drain) begin
        swap_count_q <= swap_count_q + 8'd1;
      end

      // Abort outside a copy clears the sticky flag even if a write collides.
      if (bus.abort_i && state != COPY) begin
        overflow_q <= 1'b0;
      end else if (bus.wr_valid_i && !wr_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule
